// File: rtl/neuro_skin_pkg.sv
// Shared constants and state encoding for the max-channel pixel stream path.
package neuro_skin_pkg;

    localparam int PIX_W         = 10;
    localparam int CNT_W_DEFAULT = 20;

    localparam logic [1:0] IDX_RED   = 2'd0;
    localparam logic [1:0] IDX_GREEN = 2'd1;
    localparam logic [1:0] IDX_BLUE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/rgb_argmax.sv
// Combinational 3-way maximum of an RGB pixel; ties resolve red > green > blue.
module rgb_argmax
    import neuro_skin_pkg::*;
(
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    output logic [PIX_W-1:0] max_value,
    output logic [1:0]       max_index
);

    always_comb begin
        max_value = red;
        max_index = IDX_RED;
        if (!(red >= green && red >= blue)) begin
            if (green >= blue) begin
                max_value = green;
                max_index = IDX_GREEN;
            end else begin
                max_value = blue;
                max_index = IDX_BLUE;
            end
        end
    end

endmodule

// File: rtl/max_stream_ctrl.sv
// Streams the largest channel of each pixel and reports per-frame winner counts.
module max_stream_ctrl
    import neuro_skin_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_value,
    output logic [1:0]       out_index,
    output logic             stat_valid,
    output logic [CNT_W-1:0] stat_red,
    output logic [CNT_W-1:0] stat_green,
    output logic [CNT_W-1:0] stat_blue,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic             out_valid_reg;
    logic [PIX_W-1:0] out_value_reg;
    logic [1:0]       out_index_reg;
    logic [CNT_W-1:0] cnt_reg [0:2];

    logic [PIX_W-1:0] win_value;
    logic [1:0]       win_index;
    logic             accept;
    logic             xfer;
    logic             stat_fire;

    rgb_argmax u_argmax (
        .red       (red),
        .green     (green),
        .blue      (blue),
        .max_value (win_value),
        .max_index (win_index)
    );

    assign in_ready = ce & (state_reg != ST_REPORT) & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_reg & out_ready & ce;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else if (ce) begin
            state_reg <= state_next;
        end
    end

    // Next state; the report pulse waits until the last result has left the output register
    always_comb begin
        state_next = state_reg;
        stat_fire  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = in_last ? ST_REPORT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (ce && (!out_valid_reg || out_ready)) begin
                    stat_fire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_value_reg <= '0;
            out_index_reg <= IDX_RED;
        end else if (ce) begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_value_reg <= win_value;
                out_index_reg <= win_index;
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // The first pixel of a frame restarts the counts, so they double as the held statistics
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic hit;
            assign hit = (win_index == 2'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (accept) begin
                    if (state_reg == ST_IDLE) begin
                        cnt_reg[gi] <= hit ? CNT_W'(1) : '0;
                    end else if (hit && cnt_reg[gi] != CNT_MAX) begin
                        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    assign out_valid  = out_valid_reg;
    assign out_value  = out_value_reg;
    assign out_index  = out_index_reg;
    assign stat_valid = stat_fire;
    assign stat_red   = cnt_reg[0];
    assign stat_green = cnt_reg[1];
    assign stat_blue  = cnt_reg[2];
    assign busy       = (state_reg != ST_IDLE) | out_valid_reg;

endmodule

// File: tb/tb_max_stream_ctrl.sv
// Directed bench: default-width instance plus a 3-bit-counter instance sharing one stimulus.
module tb_max_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       in_valid;
    logic       in_last;
    logic [9:0] red, green, blue;
    logic       out_ready;

    logic        in_ready, out_valid, stat_valid, busy;
    logic [9:0]  out_value;
    logic [1:0]  out_index;
    logic [19:0] stat_red, stat_green, stat_blue;

    logic        s_in_ready, s_out_valid, s_stat_valid, s_busy;
    logic [9:0]  s_out_value;
    logic [1:0]  s_out_index;
    logic [2:0]  s_stat_red, s_stat_green, s_stat_blue;

    int total = 0;
    int fails = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    max_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .red(red), .green(green), .blue(blue),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_index(out_index),
        .stat_valid(stat_valid), .stat_red(stat_red),
        .stat_green(stat_green), .stat_blue(stat_blue), .busy(busy)
    );

    max_stream_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
        .red(red), .green(green), .blue(blue),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_value(s_out_value), .out_index(s_out_index),
        .stat_valid(s_stat_valid), .stat_red(s_stat_red),
        .stat_green(s_stat_green), .stat_blue(s_stat_blue), .busy(s_busy)
    );

    always @(negedge clk) begin
        if (stat_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                       input logic last);
        in_valid = 1'b1;
        red      = r;
        green    = g;
        blue     = b;
        in_last  = last;
    endtask

    task automatic idle_in;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [9:0] v, input logic [1:0] idx);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_value"}, out_value, v);
        chk({tag, "_index"}, out_index, idx);
        $display("out %s: value=%0d index=%0d", tag, out_value, out_index);
    endtask

    task automatic chk_stat(input string tag, input int r, input int g, input int b);
        chk({tag, "_pulse"}, stat_valid, 1);
        chk({tag, "_red"}, stat_red, r);
        chk({tag, "_green"}, stat_green, g);
        chk({tag, "_blue"}, stat_blue, b);
        $display("stat %s: red=%0d green=%0d blue=%0d", tag, stat_red, stat_green, stat_blue);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; out_ready = 1'b1;
        red = '0; green = '0; blue = '0;
        idle_in();
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_stat_valid", stat_valid, 0);
        chk("rst_stat_red", stat_red, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Frame A: G, R(tie), G(tie) with last on the third
        pix(100, 200, 50, 0); #1;
        chk("a0_in_ready", in_ready, 1);
        tick();
        chk_out("a0", 200, 1);
        chk("a0_busy", busy, 1);
        pix(7, 7, 3, 0); tick();
        chk_out("a1_tie", 7, 0);
        pix(0, 9, 9, 1); tick();
        idle_in(); #1;
        chk_out("a2_tie", 9, 1);
        chk("a_report_in_ready", in_ready, 0);
        chk_stat("a", 1, 2, 0);
        tick();
        chk("a_pulse_end", stat_valid, 0);
        chk("a_out_drained", out_valid, 0);
        chk("a_busy_end", busy, 0);

        // Frame B: R, G, B, R
        pix(300, 1, 2, 0); tick();
        pix(1, 300, 2, 0); tick();
        pix(1, 2, 300, 0); tick();
        chk_out("b2", 300, 2);
        pix(5, 4, 3, 1); tick();
        idle_in(); #1;
        chk_out("b3", 5, 0);
        chk("b_report_in_ready", in_ready, 0);
        chk_stat("b", 2, 1, 1);
        tick();
        chk("b_pulse_end", stat_valid, 0);

        // Frame C: backpressure, then deferred report under ce low
        pix(10, 20, 30, 0); tick();
        chk_out("c0", 30, 2);
        out_ready = 1'b0;
        pix(40, 5, 5, 0); #1;
        chk("c_stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("c_stall", 30, 2);
            chk("c_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; #1;
        chk("c_release_in_ready", in_ready, 1);
        tick();
        chk_out("c1", 40, 0);
        pix(5, 50, 5, 0); tick();
        chk_out("c2", 50, 1);
        pix(5, 5, 60, 1); tick();
        idle_in(); out_ready = 1'b0; #1;
        chk_out("c3", 60, 2);
        chk("c_report_wait_pulse", stat_valid, 0);
        chk("c_report_busy", busy, 1);
        tick();
        chk("c_report_wait_pulse2", stat_valid, 0);
        chk_out("c3_hold", 60, 2);
        ce = 1'b0; out_ready = 1'b1; #1;
        chk("c_ce_low_pulse", stat_valid, 0);
        chk("c_ce_low_in_ready", in_ready, 0);
        tick();
        chk("c_ce_low_frozen", out_valid, 1);
        ce = 1'b1; #1;
        chk_stat("c", 1, 1, 2);
        tick();
        chk("c_pulse_end", stat_valid, 0);
        chk("c_out_drained", out_valid, 0);
        chk("c_busy_end", busy, 0);

        // Frame D: ten red winners; 3-bit instance saturates at 7
        for (int i = 0; i < 10; i++) begin
            pix(50, 1, 1, (i == 9));
            tick();
        end
        idle_in(); #1;
        chk_stat("d", 10, 0, 0);
        chk("d_sat_pulse", s_stat_valid, 1);
        chk("d_sat_red", s_stat_red, 7);
        $display("stat d_sat: red=%0d", s_stat_red);
        tick();

        // Frame E: aborted by reset after three pixels, then single-pixel frame
        for (int i = 0; i < 3; i++) begin
            pix(9, 1, 1, 0);
            tick();
        end
        idle_in(); rst_n = 1'b0; tick();
        chk("e_rst_pulse", stat_valid, 0);
        chk("e_rst_out_valid", out_valid, 0);
        chk("e_rst_busy", busy, 0);
        chk("e_rst_red", stat_red, 0);
        rst_n = 1'b1;
        pix(1, 2, 3, 1); tick();
        idle_in(); #1;
        chk_out("f0", 3, 2);
        chk_stat("f", 0, 0, 1);
        tick();
        chk("f_pulse_end", stat_valid, 0);

        tick();
        chk("pulse_count", pulses, 5);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
